// File: rtl/uart_imem_loader_pkg.sv
// Shared types and default constants for the UART instruction-memory loader.
package uart_imem_loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int unsigned DEF_CLKS_PER_BIT = 868;
  localparam logic [31:0] DEF_BASE_ADDR    = 32'h0000_0000;
  localparam logic [31:0] DEF_END_MARKER   = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_imem_loader_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte and
// framing-error pulses.
module uart_rx_core
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err_pulse
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state_q, state_d;
  logic             rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) valid_d = 1'b1;
          else ferr_d = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign byte_out        = shift_q;
  assign byte_valid      = valid_q;
  assign frame_err_pulse = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Loads little-endian 32-bit words received over UART into instruction memory,
// one write strobe per word, with prog-level session control.
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter logic [31:0] END_MARKER   = DEF_END_MARKER
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        prog,
  input  logic        rx,
  output logic [31:0] uart_dout,
  output logic        memcon_prog_ena,
  output logic [31:0] prog_addr,
  output logic        prog_done,
  output logic        frame_err,
  output logic [15:0] word_count
);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ferr;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk             (clk),
    .Rst             (Rst),
    .rx              (rx),
    .byte_out        (rx_byte),
    .byte_valid      (rx_valid),
    .frame_err_pulse (rx_ferr)
  );

  logic        prog_prev_q;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] dout_q, dout_d;
  logic [31:0] paddr_q, paddr_d;
  logic        ena_q, ena_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic [15:0] wcount_q, wcount_d;
  logic        prog_fall, prog_rise;

  assign prog_fall = prog_prev_q & ~prog;
  assign prog_rise = ~prog_prev_q & prog;

  always_comb begin
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    paddr_d    = paddr_q;
    ena_d      = 1'b0;
    done_d     = done_q;
    ferr_d     = ferr_q | rx_ferr;
    wcount_d   = wcount_q;

    // The strobe is registered, so a byte accepted here writes next cycle;
    // a byte arriving as prog drops is already rejected by the prog term.
    if (rx_valid && prog && !done_q) begin
      word_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
      byte_idx_d = byte_idx_q + 2'd1;
      if (byte_idx_q == 2'd3) begin
        if (word_d == END_MARKER) begin
          done_d = 1'b1;
        end else begin
          dout_d  = word_d;
          paddr_d = addr_q;
          ena_d   = 1'b1;
          addr_d  = addr_q + 32'd4;
          if (wcount_q != '1) wcount_d = wcount_q + 16'd1;
        end
      end
    end

    if (prog_fall) begin
      byte_idx_d = '0;
      word_d     = '0;
      done_d     = 1'b0;
      ferr_d     = 1'b0;
      addr_d     = BASE_ADDR;
      ena_d      = 1'b0;
    end
    if (prog_rise) wcount_d = '0;
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      prog_prev_q <= 1'b0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      addr_q      <= BASE_ADDR;
      dout_q      <= '0;
      paddr_q     <= BASE_ADDR;
      ena_q       <= 1'b0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      wcount_q    <= '0;
    end else begin
      prog_prev_q <= prog;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      paddr_q     <= paddr_d;
      ena_q       <= ena_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
      wcount_q    <= wcount_d;
    end
  end

  assign uart_dout       = dout_q;
  assign prog_addr       = paddr_q;
  assign memcon_prog_ena = ena_q;
  assign prog_done       = done_q;
  assign frame_err       = ferr_q;
  assign word_count      = wcount_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: a session-level reference model
// predicts every imem write and the sticky status outputs.
module tb_uart_imem_loader;

  localparam int unsigned CPB  = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] MARK = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        Rst, prog, rx;
  logic [31:0] uart_dout, prog_addr;
  logic        memcon_prog_ena, prog_done, frame_err;
  logic [15:0] word_count;

  always #5 clk = ~clk;

  uart_imem_loader #(
    .CLKS_PER_BIT (CPB),
    .BASE_ADDR    (BASE),
    .END_MARKER   (MARK)
  ) dut (
    .clk             (clk),
    .Rst             (Rst),
    .prog            (prog),
    .rx              (rx),
    .uart_dout       (uart_dout),
    .memcon_prog_ena (memcon_prog_ena),
    .prog_addr       (prog_addr),
    .prog_done       (prog_done),
    .frame_err       (frame_err),
    .word_count      (word_count)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // expected writes: {address, data}
  logic [63:0] exp_q[$];

  // reference model state
  logic [31:0] m_addr, m_last_addr, m_last_data;
  logic [7:0]  m_bytes[4];
  int          m_idx;
  bit          m_done, m_ferr, m_prog;
  logic [15:0] m_count;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_addr      = BASE;
    m_last_addr = BASE;
    m_last_data = '0;
    m_idx       = 0;
    m_done      = 1'b0;
    m_ferr      = 1'b0;
    m_count     = '0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    logic [31:0] w;
    if (!stop_ok) begin
      m_ferr = 1'b1;
    end else if (m_prog && !m_done) begin
      m_bytes[m_idx] = b;
      m_idx++;
      if (m_idx == 4) begin
        m_idx = 0;
        w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        if (w == MARK) begin
          m_done = 1'b1;
        end else begin
          exp_q.push_back({m_addr, w});
          m_last_addr = m_addr;
          m_last_data = w;
          m_addr      = m_addr + 32'd4;
          if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        end
      end
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = stop_ok;
    wait_clks(CPB);
    rx = 1'b1;
    wait_clks(stop_ok ? 4 : 2 * CPB);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic set_prog(input bit v);
    if (m_prog && !v) begin
      m_idx  = 0;
      m_done = 1'b0;
      m_ferr = 1'b0;
      m_addr = BASE;
    end
    if (!m_prog && v) m_count = '0;
    m_prog = v;
    prog   = v;
    wait_clks(3);
  endtask

  task automatic check_status(input string tag);
    check32({tag, ".word_count"}, {16'h0, word_count}, {16'h0, m_count});
    check32({tag, ".prog_done"}, {31'h0, prog_done}, {31'h0, m_done});
    check32({tag, ".frame_err"}, {31'h0, frame_err}, {31'h0, m_ferr});
    check32({tag, ".uart_dout"}, uart_dout, m_last_data);
    check32({tag, ".prog_addr"}, prog_addr, m_last_addr);
    check32({tag, ".strobe_ena"}, {31'h0, memcon_prog_ena}, 32'h0);
    check32({tag, ".missing_strobes"}, exp_q.size(), 32'd0);
  endtask

  // monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (Rst === 1'b0 && memcon_prog_ena === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got addr %h data %h, required no strobe",
                 prog_addr, uart_dout);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check32("strobe_addr", prog_addr, e[63:32]);
        check32("strobe_data", uart_dout, e[31:0]);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    Rst    = 1'b1;
    prog   = 1'b0;
    rx     = 1'b1;
    m_prog = 1'b0;
    model_reset();
    wait_clks(5);
    check_status("reset");
    Rst = 1'b0;
    wait_clks(5);

    // single word
    set_prog(1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check_status("single_word");
    check32("single_word.value", uart_dout, 32'h0000_0513);

    // two words then end marker; later bytes ignored
    set_prog(1'b0);
    set_prog(1'b1);
    send_word($urandom);
    send_word($urandom);
    send_word(MARK);
    check_status("end_marker");
    check32("end_marker.count", {16'h0, word_count}, 32'd2);
    send_word($urandom);
    check_status("after_done");

    // framing error does not disturb byte alignment
    set_prog(1'b0);
    set_prog(1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    check_status("frame_err");
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    send_word($urandom);
    check_status("after_frame_err");

    // short low glitch must not produce a byte
    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    wait_clks(3 * CPB);
    send_word($urandom);
    check_status("glitch");

    // partial word discarded across a prog toggle
    set_prog(1'b0);
    set_prog(1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    set_prog(1'b0);
    check_status("prog_drop");
    set_prog(1'b1);
    send_word($urandom);
    check_status("prog_restart");

    // randomized traffic with session toggles, framing errors and markers
    for (int it = 0; it < 40; it++) begin
      int unsigned r;
      r = $urandom_range(0, 19);
      if (!m_prog && r < 12) set_prog(1'b1);
      else if (r == 0) set_prog(~m_prog);
      else if (r == 1) send_byte(8'($urandom), 1'b0);
      else if (r == 2) send_word(MARK);
      else send_byte(8'($urandom), 1'b1);
    end
    check_status("random");

    // reset in the middle of the fourth byte
    set_prog(1'b0);
    set_prog(1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = 1'($urandom);
      wait_clks(CPB);
    end
    Rst = 1'b1;
    model_reset();
    wait_clks(2);
    check_status("rst_mid_frame");
    rx = 1'b1;
    wait_clks(2);
    Rst = 1'b0;
    wait_clks(12 * CPB);
    check_status("after_rst");
    send_word($urandom);
    check_status("post_rst_word");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud); minimum 4.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, first instruction-memory address written.
REQ-003 Parameter END_MARKER, default 32'hFFFF_FFFF, word that terminates a load.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 Rst  input  1  reset, asynchronous, active-high.
REQ-006 prog  input  1  programming mode enable; level-sensitive.
REQ-007 rx  input  1  UART serial input, 8N1, idle high, asynchronous to clk.
REQ-008 uart_dout  output  32  assembled instruction word to imem.
REQ-009 memcon_prog_ena  output  1  one-cycle imem write strobe.
REQ-010 prog_addr  output  32  byte address for uart_dout, valid with memcon_prog_ena.
REQ-011 prog_done  output  1  sticky; END_MARKER received in current session.
REQ-012 frame_err  output  1  sticky; stop bit sampled low.
REQ-013 word_count  output  16  words written this session, saturating at 16'hFFFF.

Function
REQ-014 rx SHALL pass a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-015 RX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on synchronized rx = 0; bit counter cleared.
REQ-017 START SHALL sample at CLKS_PER_BIT/2 cycles; sample 0 -> DATA, sample 1 -> IDLE (glitch rejected, no byte).
REQ-018 DATA SHALL sample 8 bits LSB first, every CLKS_PER_BIT cycles after the start-bit midpoint.
REQ-019 STOP SHALL sample CLKS_PER_BIT cycles after bit 7. Sample 1: one-cycle byte_valid. Sample 0: set frame_err and discard the byte. Either way -> IDLE.
REQ-020 The RX FSM SHALL run regardless of prog. Bytes completed while prog = 0 SHALL be discarded.
REQ-021 Bytes SHALL assemble little-endian: first byte of a word -> [7:0], fourth byte -> [31:24].
REQ-022 The cycle after the fourth byte_valid: uart_dout = word, prog_addr = address counter, memcon_prog_ena = 1 for exactly one cycle.
REQ-023 Address counter SHALL then increment by 4, wrapping modulo 2^32. word_count SHALL increment, saturating.
REQ-024 A word equal to END_MARKER SHALL NOT be written and SHALL set prog_done.
REQ-025 While prog_done = 1, further bytes SHALL be discarded.
REQ-026 prog 1 -> 0 SHALL clear byte index, partial word, prog_done and frame_err, and reload address counter to BASE_ADDR. word_count SHALL hold its value until the next prog 0 -> 1.
REQ-027 prog 0 -> 1 SHALL clear word_count.
REQ-028 If prog falls in the same cycle a write would issue, the write SHALL be suppressed.
REQ-029 uart_dout and prog_addr SHALL hold their last values between strobes.

Reset
REQ-030 Rst SHALL force: RX FSM = IDLE, synchronizer flops = 1, counters = 0, address = BASE_ADDR, uart_dout = 0, prog_addr = BASE_ADDR, memcon_prog_ena = 0, prog_done = 0, frame_err = 0, word_count = 0.
REQ-031 Rst asserted mid-frame SHALL abort the frame; no write SHALL follow release.
REQ-032 After Rst release, the first byte SHALL be accepted only on a fresh start bit.

Structure
REQ-033 Shared package SHALL hold the RX state enum and the default CLKS_PER_BIT and END_MARKER constants.
REQ-034 Bit-level deserialization SHALL live in sub-module uart_rx_core (ports: clk, Rst, rx, byte_out[7:0], byte_valid, frame_err_pulse).
REQ-035 Word assembly, address counter and session control SHALL live in the top module.

Verification (CLKS_PER_BIT = 16)
REQ-036 prog = 1; send bytes 13 05 00 00 -> one strobe, uart_dout = 32'h0000_0513, prog_addr = 0, word_count = 1.
REQ-037 prog = 1; send 8 bytes, then FF FF FF FF -> strobes at addresses 0 and 4, no third strobe, prog_done = 1, word_count = 2.
REQ-038 Byte with stop bit forced 0 -> frame_err = 1, byte index unchanged; next valid 4 bytes write at the expected address.
REQ-039 rx low pulse of 4 cycles -> no byte_valid, FSM back in IDLE.
REQ-040 Send 2 bytes, drop prog, raise prog, send 4 bytes -> single write at BASE_ADDR with only the new bytes.
REQ-041 Assert Rst during DATA of the 4th byte -> no strobe; all outputs at reset values.
